// File: rtl/mem_test_data_bus_ctrl_if.sv
// Memory port between the data bus test sequencer (master) and the memory under test (slave).
interface mem_test_data_bus_ctrl_if #(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ADDR_WIDTH = 8
);
  logic [p_ADDR_WIDTH-1:0] o_MEM_ADDR;
  logic [p_DATA_WIDTH-1:0] o_MEM_WDATA;
  logic                    o_MEM_WE;
  logic                    o_MEM_RE;
  logic [p_DATA_WIDTH-1:0] i_MEM_RDATA;
  logic                    i_MEM_RVALID;

  modport master (
    output o_MEM_ADDR, o_MEM_WDATA, o_MEM_WE, o_MEM_RE,
    input  i_MEM_RDATA, i_MEM_RVALID
  );

  modport slave (
    input  o_MEM_ADDR, o_MEM_WDATA, o_MEM_WE, o_MEM_RE,
    output i_MEM_RDATA, i_MEM_RVALID
  );
endinterface

// File: rtl/mem_test_data_bus_ctrl.sv
// Walking-ones data bus test of one memory location: write each one-hot pattern,
// read it back, stop on the first mismatch or read timeout and report the result.
module mem_test_data_bus_ctrl #(
  parameter int p_DATA_WIDTH = 8,
  parameter int p_ADDR_WIDTH = 8,
  parameter int p_TEST_ADDR  = 0,
  parameter int p_TIMEOUT    = 15
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic                    i_START,
  output logic                    o_BUSY,
  output logic                    o_DONE,
  output logic                    o_FAIL,
  output logic                    o_TIMEOUT,
  output logic [p_DATA_WIDTH-1:0] o_FAIL_PATTERN,
  output logic [p_DATA_WIDTH-1:0] o_FAIL_DATA,
  mem_test_data_bus_ctrl_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(p_TIMEOUT - 1);

  state_t                  state_reg, state_next;
  logic [p_DATA_WIDTH-1:0] pattern_reg, pattern_next;
  logic [7:0]              tmo_cnt_reg, tmo_cnt_next;
  logic                    fail_reg, fail_next;
  logic                    timeout_reg, timeout_next;
  logic [p_DATA_WIDTH-1:0] fail_pattern_reg, fail_pattern_next;
  logic [p_DATA_WIDTH-1:0] fail_data_reg, fail_data_next;

  // Reset asserts asynchronously but is released two clocks after i_RST_N rises.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) rst_sync_reg <= 2'b00;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  always_ff @(posedge i_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      pattern_reg      <= '0;
      tmo_cnt_reg      <= '0;
      fail_reg         <= 1'b0;
      timeout_reg      <= 1'b0;
      fail_pattern_reg <= '0;
      fail_data_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      pattern_reg      <= pattern_next;
      tmo_cnt_reg      <= tmo_cnt_next;
      fail_reg         <= fail_next;
      timeout_reg      <= timeout_next;
      fail_pattern_reg <= fail_pattern_next;
      fail_data_reg    <= fail_data_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    pattern_next      = pattern_reg;
    tmo_cnt_next      = tmo_cnt_reg;
    fail_next         = fail_reg;
    timeout_next      = timeout_reg;
    fail_pattern_next = fail_pattern_reg;
    fail_data_next    = fail_data_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (i_START) begin
          state_next        = S_WRITE;
          pattern_next      = {{(p_DATA_WIDTH-1){1'b0}}, 1'b1};
          fail_next         = 1'b0;
          timeout_next      = 1'b0;
          fail_pattern_next = '0;
          fail_data_next    = '0;
        end
      end
      S_WRITE: state_next = S_READ;
      S_READ: begin
        tmo_cnt_next = '0;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        // Valid data on the final allowed cycle takes priority over the timeout.
        if (mem.i_MEM_RVALID) begin
          if (mem.i_MEM_RDATA == pattern_reg) begin
            if (pattern_reg[p_DATA_WIDTH-1]) begin
              state_next = S_DONE;
            end else begin
              pattern_next = pattern_reg << 1;
              state_next   = S_WRITE;
            end
          end else begin
            state_next        = S_DONE;
            fail_next         = 1'b1;
            fail_pattern_next = pattern_reg;
            fail_data_next    = mem.i_MEM_RDATA;
          end
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next        = S_DONE;
          fail_next         = 1'b1;
          timeout_next      = 1'b1;
          fail_pattern_next = pattern_reg;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 8'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_BUSY         = (state_reg == S_WRITE) || (state_reg == S_READ) || (state_reg == S_WAIT);
  assign o_DONE         = (state_reg == S_DONE);
  assign o_FAIL         = fail_reg;
  assign o_TIMEOUT      = timeout_reg;
  assign o_FAIL_PATTERN = fail_pattern_reg;
  assign o_FAIL_DATA    = fail_data_reg;

  assign mem.o_MEM_ADDR  = p_ADDR_WIDTH'(p_TEST_ADDR);
  assign mem.o_MEM_WE    = (state_reg == S_WRITE);
  assign mem.o_MEM_RE    = (state_reg == S_READ);
  assign mem.o_MEM_WDATA = (state_reg == S_WRITE) ? pattern_reg : '0;

endmodule

// File: tb/tb_mem_test_data_bus_ctrl.sv
// Directed bench for the walking-ones sequencer with a fault-injecting memory model.
module tb_mem_test_data_bus_ctrl;
  localparam int W     = 8;
  localparam int A     = 8;
  localparam int TADDR = 8'h3C;
  localparam int TMO   = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         o_BUSY, o_DONE, o_FAIL, o_TIMEOUT;
  logic [W-1:0] o_FAIL_PATTERN, o_FAIL_DATA;

  int checks = 0;
  int errors = 0;

  mem_test_data_bus_ctrl_if #(.p_DATA_WIDTH(W), .p_ADDR_WIDTH(A)) mif ();

  mem_test_data_bus_ctrl #(
    .p_DATA_WIDTH(W), .p_ADDR_WIDTH(A), .p_TEST_ADDR(TADDR), .p_TIMEOUT(TMO)
  ) u_dut (
    .i_CLK          (clk),
    .i_RST_N        (rst_n),
    .i_START        (start),
    .o_BUSY         (o_BUSY),
    .o_DONE         (o_DONE),
    .o_FAIL         (o_FAIL),
    .o_TIMEOUT      (o_TIMEOUT),
    .o_FAIL_PATTERN (o_FAIL_PATTERN),
    .o_FAIL_DATA    (o_FAIL_DATA),
    .mem            (mif)
  );

  always #5 clk = ~clk;

  // Memory model: lat = cycles from RE edge to RVALID (0 = never answers).
  logic [W-1:0] mem_word = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] rd;
  bit           short12 = 1'b0;
  int           lat = 1;
  int           cnt = 0;
  logic [W-1:0] we_log[$];

  always @(posedge clk) begin
    if (mif.o_MEM_WE) begin
      mem_word <= mif.o_MEM_WDATA;
      we_log.push_back(mif.o_MEM_WDATA);
    end
    if (mif.o_MEM_RE)  cnt <= lat;
    else if (cnt > 0)  cnt <= cnt - 1;
  end

  always_comb begin
    rd = mem_word & ~stuck0;
    if (short12 && (rd[1] || rd[2])) rd[2:1] = 2'b11;
    mif.i_MEM_RVALID = (cnt == 1);
    mif.i_MEM_RDATA  = (cnt == 1) ? rd : '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  o_BUSY, 0);
    chk({tag, "_done"},  o_DONE, 0);
    chk({tag, "_fail"},  o_FAIL, 0);
    chk({tag, "_tmo"},   o_TIMEOUT, 0);
    chk({tag, "_fpat"},  o_FAIL_PATTERN, 0);
    chk({tag, "_fdata"}, o_FAIL_DATA, 0);
    chk({tag, "_we"},    mif.o_MEM_WE, 0);
    chk({tag, "_re"},    mif.o_MEM_RE, 0);
    chk({tag, "_wdata"}, mif.o_MEM_WDATA, 0);
    chk({tag, "_addr"},  mif.o_MEM_ADDR, TADDR);
  endtask

  // Start is sampled at edge 0; done_edge is the edge that enters DONE
  // (DONE is then visible in cycle done_edge+1).
  task automatic run_test(input string tag, input int max_edges, input bit noise,
                          output int done_edge);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    we_log.delete();
    chk({tag, "_start_busy"},  o_BUSY, 1);
    chk({tag, "_start_fail"},  o_FAIL, 0);
    chk({tag, "_start_fpat"},  o_FAIL_PATTERN, 0);
    chk({tag, "_start_wdata"}, mif.o_MEM_WDATA, 1);
    done_edge = -1;
    for (int n = 1; n <= max_edges; n++) begin
      @(posedge clk); #1;
      if (o_DONE) begin
        done_edge = n;
        break;
      end
      start = noise && (n % 4 == 1);
    end
    start = 1'b0;
    if (done_edge < 0) begin
      checks++; errors++;
      $error("FAIL %s_no_done: got no DONE within %0d cycles expected DONE", tag, max_edges);
    end else begin
      chk({tag, "_busy_fall"}, o_BUSY, 0);
    end
    $display("run %s: done_edge=%0d fail=%0b tmo=%0b fpat=0x%0h fdata=0x%0h writes=%0d",
             tag, done_edge, o_FAIL, o_TIMEOUT, o_FAIL_PATTERN, o_FAIL_DATA, we_log.size());
  endtask

  initial begin
    int e;
    // Reset state
    #2 chk_idle_outputs("rst_async");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk_idle_outputs("rst_idle");

    // Ideal 1-cycle memory: 8 patterns x 3 cycles
    lat = 1;
    run_test("ideal", 60, 1'b0, e);
    chk("ideal_edge", e, 24);
    chk("ideal_fail", o_FAIL, 0);
    chk("ideal_tmo", o_TIMEOUT, 0);
    chk("ideal_fpat", o_FAIL_PATTERN, 0);
    chk("ideal_nwe", we_log.size(), 8);
    for (int i = 0; i < 8 && i < we_log.size(); i++) chk($sformatf("ideal_we%0d", i), we_log[i], 32'(1) << i);

    // Bit 3 stuck at 0: fails reading pattern 0x08 (k=3, WAIT ends at edge 12)
    stuck0 = 8'h08;
    run_test("stuck3", 60, 1'b0, e);
    chk("stuck3_edge", e, 12);
    chk("stuck3_fail", o_FAIL, 1);
    chk("stuck3_fpat", o_FAIL_PATTERN, 8'h08);
    chk("stuck3_fdata", o_FAIL_DATA, 8'h00);
    chk("stuck3_tmo", o_TIMEOUT, 0);
    chk("stuck3_nwe", we_log.size(), 4);
    stuck0 = '0;

    // Restart from a failed DONE: flags clear, then a clean pass
    run_test("restart", 60, 1'b0, e);
    chk("restart_edge", e, 24);
    chk("restart_fail", o_FAIL, 0);
    chk("restart_fdata", o_FAIL_DATA, 0);

    // Bits 1/2 shorted: pattern 0x02 reads back 0x06
    short12 = 1'b1;
    run_test("short", 60, 1'b0, e);
    chk("short_edge", e, 6);
    chk("short_fail", o_FAIL, 1);
    chk("short_fpat", o_FAIL_PATTERN, 8'h02);
    chk("short_fdata", o_FAIL_DATA, 8'h06);
    chk("short_nwe", we_log.size(), 2);
    short12 = 1'b0;

    // No RVALID: 15 WAIT cycles (cycles 3..17) then DONE entered at edge 17
    lat = 0;
    run_test("tmo", 60, 1'b0, e);
    chk("tmo_edge", e, 17);
    chk("tmo_fail", o_FAIL, 1);
    chk("tmo_tmo", o_TIMEOUT, 1);
    chk("tmo_fpat", o_FAIL_PATTERN, 8'h01);
    chk("tmo_fdata", o_FAIL_DATA, 0);
    chk("tmo_nwe", we_log.size(), 1);

    // RVALID on the 15th WAIT cycle wins: 17 cycles per pattern
    lat = 15;
    run_test("lastcyc", 200, 1'b0, e);
    chk("lastcyc_edge", e, 136);
    chk("lastcyc_fail", o_FAIL, 0);
    chk("lastcyc_tmo", o_TIMEOUT, 0);

    // 3-cycle read latency: 5 cycles per pattern
    lat = 3;
    run_test("lat3", 100, 1'b0, e);
    chk("lat3_edge", e, 40);
    chk("lat3_fail", o_FAIL, 0);

    // START pulses while busy are ignored
    lat = 1;
    run_test("noise", 60, 1'b1, e);
    chk("noise_edge", e, 24);
    chk("noise_nwe", we_log.size(), 8);
    chk("noise_fail", o_FAIL, 0);

    // Reset during WAIT of pattern 0x10 (k=4, WAIT in cycle 15)
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    we_log.delete();
    repeat (14) @(posedge clk);
    #1 chk("rstmid_busy", o_BUSY, 1);
    chk("rstmid_nwe_pre", we_log.size(), 5);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("rstmid_async");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk_idle_outputs("rstmid_idle");
    chk("rstmid_nwe_post", we_log.size(), 5);
    $display("run rstmid: writes=%0d busy=%0b done=%0b", we_log.size(), o_BUSY, o_DONE);

    run_test("after_rst", 60, 1'b0, e);
    chk("after_rst_edge", e, 24);
    chk("after_rst_fail", o_FAIL, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
